// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame geometry and parity helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_RX           = 3'd1,
        ST_TX_INHIBIT   = 3'd2,
        ST_TX_RTS       = 3'd3,
        ST_TX_SHIFT     = 3'd4,
        ST_TX_ACK       = 3'd5,
        ST_TX_WAIT_IDLE = 3'd6
    } ps2_state_e;

    localparam int FRAME_BITS = 11;   // start, 8 data, parity, stop
    localparam int CNT_W      = 20;   // shared inhibit / RTS / timeout counter
    localparam int BIT_W      = 4;    // bit index, saturates at FRAME_BITS

    // Odd-parity bit for a data byte: set when the byte has an even number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    // Frame check on an LSB-first frame: start=0, stop=1, odd parity over data+parity.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] frame);
        return (frame[0] == 1'b0) && (frame[10] == 1'b1) && ((^frame[9:1]) == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Input conditioning for one PS/2 line: 2-FF synchronizer, debounce, edge pulses.
// The filtered level only changes after FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_level,
    output logic o_fall,
    output logic o_rise
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [FW-1:0] r_run;
    logic          r_fall;
    logic          r_rise;

    // Two-stage synchronizer, preset to the idle (released) level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_line};
        end
    end

    // Debounce: count disagreeing samples, flip the level and pulse on acceptance.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level <= 1'b1;
            r_run   <= '0;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
        end else if (r_sync[1] == r_level) begin
            r_run   <= '0;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
        end else if (r_run == FW'(FILTER_LEN - 1)) begin
            r_level <= r_sync[1];
            r_run   <= '0;
            r_fall  <= ~r_sync[1];
            r_rise  <= r_sync[1];
        end else begin
            r_run   <= r_run + FW'(1);
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;
    assign o_rise  = r_rise;

endmodule

// File: rtl/ps2_host_port.sv
// Host-side PS/2 transceiver: sends one command byte (inhibit, RTS, shift, ack)
// and receives device-to-host frames. Lines are open-drain: driven 0 or released.
module ps2_host_port
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       qzt_clk,
    input  logic       reset,
    inout  wire        PS2C,
    inout  wire        PS2D,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_SAT  = BIT_W'(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_PAR  = BIT_W'(8);

    ps2_state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_step, w_cnt_nxt;
    logic [BIT_W-1:0]      r_bit, w_bit_nxt, w_bit_inc;
    logic [FRAME_BITS-1:0] r_shift, w_shift_nxt, w_frame;
    logic [7:0]            r_tx_byte, w_tx_byte_nxt;
    logic [7:0]            r_rx_data, w_rx_data_nxt;
    logic                  r_drive_c, w_drive_c_nxt;
    logic                  r_drive_d, w_drive_d_nxt;
    logic                  r_tx_busy, r_tx_done, r_tx_error, r_rx_valid, r_rx_error;
    logic                  w_tx_done_nxt, w_tx_error_nxt, w_rx_valid_nxt, w_rx_error_nxt;
    logic                  w_c_level, w_c_fall, w_c_rise;
    logic                  w_d_level, w_d_fall, w_d_rise;
    logic                  w_timeout;
    logic                  w_unused_bits;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .i_clk   (qzt_clk),
        .i_reset (reset),
        .i_line  (PS2C),
        .o_level (w_c_level),
        .o_fall  (w_c_fall),
        .o_rise  (w_c_rise)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .i_clk   (qzt_clk),
        .i_reset (reset),
        .i_line  (PS2D),
        .o_level (w_d_level),
        .o_fall  (w_d_fall),
        .o_rise  (w_d_rise)
    );

    // Only the clock falling edge and the levels drive the protocol.
    assign w_unused_bits = w_c_rise ^ w_d_fall ^ w_d_rise ^ r_shift[0];

    // Frame as it looks after shifting in the current data sample (LSB first).
    assign w_frame   = {w_d_level, r_shift[FRAME_BITS-1:1]};
    assign w_bit_inc = (r_bit == BIT_SAT) ? r_bit : (r_bit + BIT_W'(1));
    assign w_timeout = (r_cnt >= TMO_LAST);

    // Next-state, datapath and output-pulse logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_step     = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));
        w_bit_nxt      = r_bit;
        w_shift_nxt    = r_shift;
        w_tx_byte_nxt  = r_tx_byte;
        w_rx_data_nxt  = r_rx_data;
        w_drive_c_nxt  = r_drive_c;
        w_drive_d_nxt  = r_drive_d;
        w_tx_done_nxt  = 1'b0;
        w_tx_error_nxt = 1'b0;
        w_rx_valid_nxt = 1'b0;
        w_rx_error_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_drive_c_nxt = 1'b0;
                w_drive_d_nxt = 1'b0;
                if (tx_start) begin
                    // A send request outranks a device frame starting in the same cycle.
                    w_state_nxt   = ST_TX_INHIBIT;
                    w_tx_byte_nxt = tx_data;
                    w_drive_c_nxt = 1'b1;
                end else if (w_c_fall) begin
                    w_state_nxt = ST_RX;
                    w_shift_nxt = w_frame;
                    w_bit_nxt   = BIT_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RX: begin
                if (w_c_fall) begin
                    w_shift_nxt = w_frame;
                    w_bit_nxt   = w_bit_inc;
                    w_cnt_step  = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        if (frame_ok(w_frame)) begin
                            w_rx_data_nxt  = w_frame[8:1];
                            w_rx_valid_nxt = 1'b1;
                        end else begin
                            w_rx_error_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_RX;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = ST_IDLE;
                    w_rx_error_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_RX;
                end
            end
            ST_TX_INHIBIT: begin
                if (r_cnt >= INH_LAST) begin
                    w_state_nxt   = ST_TX_RTS;
                    w_drive_d_nxt = 1'b1;   // data low = start bit
                end else begin
                    w_state_nxt = ST_TX_INHIBIT;
                end
            end
            ST_TX_RTS: begin
                if (r_cnt >= RTS_LAST) begin
                    w_state_nxt   = ST_TX_SHIFT;
                    w_drive_c_nxt = 1'b0;
                    w_bit_nxt     = '0;
                end else begin
                    w_state_nxt = ST_TX_RTS;
                end
            end
            ST_TX_SHIFT: begin
                if (w_c_fall) begin
                    w_cnt_step = '0;
                    w_bit_nxt  = w_bit_inc;
                    if (r_bit < BIT_PAR) begin
                        w_drive_d_nxt = ~r_tx_byte[r_bit[2:0]];
                    end else if (r_bit == BIT_PAR) begin
                        w_drive_d_nxt = ~odd_parity(r_tx_byte);
                    end else begin
                        // Release for the stop bit; the device answers with its ack.
                        w_drive_d_nxt = 1'b0;
                        w_state_nxt   = ST_TX_ACK;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = ST_IDLE;
                    w_drive_c_nxt  = 1'b0;
                    w_drive_d_nxt  = 1'b0;
                    w_tx_error_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_TX_SHIFT;
                end
            end
            ST_TX_ACK: begin
                // The ack is judged on the device's next clock fall, so the tail of a
                // low parity bit still in the filter cannot be mistaken for an ack.
                if (w_c_fall) begin
                    w_cnt_step = '0;
                    if (!w_d_level) begin
                        w_state_nxt = ST_TX_WAIT_IDLE;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                        w_tx_error_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = ST_IDLE;
                    w_drive_c_nxt  = 1'b0;
                    w_drive_d_nxt  = 1'b0;
                    w_tx_error_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_TX_ACK;
                end
            end
            ST_TX_WAIT_IDLE: begin
                if (w_c_level && w_d_level) begin
                    w_state_nxt   = ST_IDLE;
                    w_tx_done_nxt = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt    = ST_IDLE;
                    w_drive_c_nxt  = 1'b0;
                    w_drive_d_nxt  = 1'b0;
                    w_tx_error_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_TX_WAIT_IDLE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_drive_c_nxt = 1'b0;
                w_drive_d_nxt = 1'b0;
            end
        endcase
        w_cnt_nxt = (w_state_nxt != r_state) ? '0 : w_cnt_step;
    end

    // State, datapath and registered outputs; reset releases both lines.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_tx_byte  <= 8'h00;
            r_rx_data  <= 8'h00;
            r_drive_c  <= 1'b0;
            r_drive_d  <= 1'b0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_drive_c  <= w_drive_c_nxt;
            r_drive_d  <= w_drive_d_nxt;
            r_tx_busy  <= (w_state_nxt != ST_IDLE);
            r_tx_done  <= w_tx_done_nxt;
            r_tx_error <= w_tx_error_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_error <= w_rx_error_nxt;
        end
    end

    assign PS2C     = r_drive_c ? 1'b0 : 1'bz;
    assign PS2D     = r_drive_d ? 1'b0 : 1'bz;
    assign tx_busy  = r_tx_busy;
    assign tx_done  = r_tx_done;
    assign tx_error = r_tx_error;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_error = r_rx_error;

endmodule

// File: tb/tb_ps2_host_port.sv
// Directed bench for ps2_host_port: device BFM on pulled-up open-drain lines,
// table-driven TX and RX vectors plus timeout and reset sequences.
module tb_ps2_host_port;

    localparam int INH = 60;
    localparam int RTS = 10;
    localparam int TMO = 1500;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_error, rx_valid, rx_error;
    logic [7:0] rx_data;
    logic       bfm_c_low, bfm_d_low;
    wire        ps2c, ps2d;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done = 0, n_txerr = 0, n_valid = 0, n_rxerr = 0, n_overlap = 0;
    int s_done, s_txerr, s_valid, s_rxerr;

    assign ps2c = bfm_c_low ? 1'b0 : 1'bz;
    assign ps2d = bfm_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    ps2_host_port #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (4)
    ) dut (
        .qzt_clk  (clk),
        .reset    (reset),
        .PS2C     (ps2c),
        .PS2D     (ps2d),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_error (tx_error),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_done  === 1'b1) n_done++;
        if (tx_error === 1'b1) n_txerr++;
        if (rx_valid === 1'b1) n_valid++;
        if (rx_error === 1'b1) n_rxerr++;
        if ((int'(tx_done === 1'b1) + int'(tx_error === 1'b1) +
             int'(rx_valid === 1'b1) + int'(rx_error === 1'b1)) > 1) n_overlap++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_done = n_done; s_txerr = n_txerr; s_valid = n_valid; s_rxerr = n_rxerr;
    endtask

    // Device-to-host: data set up, clock low 40 cycles, high 20 cycles per bit.
    task automatic send_frame(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bfm_d_low = ~fr[i];
            clocks(20);
            bfm_c_low = 1'b1;
            clocks(40);
            bfm_c_low = 1'b0;
            clocks(20);
        end
        bfm_d_low = 1'b0;
    endtask

    // Host-to-device: measure inhibit/RTS, clock n_clk bits (sampled on rising), optional ack.
    task automatic run_tx(input logic [7:0] d, input logic ack, input int n_clk,
                          output logic [9:0] bits, output int inh, output int rts);
        tx_data  = d;
        tx_start = 1'b1;
        clocks(1);
        tx_start = 1'b0;
        tx_data  = 8'h55;
        inh = 0;
        while (ps2c === 1'b0 && ps2d === 1'b1 && inh < 10 * INH) begin
            tx_start = (inh == 3);   // request while busy, must be ignored
            inh++;
            clocks(1);
        end
        tx_start = 1'b0;
        rts = 0;
        while (ps2c === 1'b0 && ps2d === 1'b0 && rts < 10 * RTS) begin
            rts++;
            clocks(1);
        end
        clocks(30);
        bits = '0;
        for (int i = 0; i < n_clk; i++) begin
            bfm_c_low = 1'b1;
            clocks(40);
            bits[i] = ps2d;
            bfm_c_low = 1'b0;
            clocks(40);
        end
        if (ack) begin
            bfm_d_low = 1'b1;
            clocks(20);
            bfm_c_low = 1'b1;
            clocks(40);
            bfm_c_low = 1'b0;
            clocks(20);
            bfm_d_low = 1'b0;
        end else begin
            bfm_d_low = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic [9:0] exp_bits;   // {stop, parity, d7..d0} as seen by the device
        int         exp_done;
        int         exp_err;
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       start;
        logic       stop;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_rx;
    } rx_vec_t;

    tx_vec_t txv[5];
    rx_vec_t rxv[7];

    initial begin
        logic [9:0] bits;
        int inh, rts, t;

        txv[0] = '{8'hF4, 1'b1, 10'h2F4, 1, 0};
        txv[1] = '{8'hA5, 1'b1, 10'h3A5, 1, 0};
        txv[2] = '{8'hF4, 1'b0, 10'h2F4, 0, 1};
        txv[3] = '{8'h00, 1'b1, 10'h300, 1, 0};
        txv[4] = '{8'hFF, 1'b1, 10'h3FF, 1, 0};

        rxv[0] = '{8'hFA, 1'b1, 1'b0, 1'b1, 1, 0, 8'hFA};
        rxv[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 1, 8'hFA};
        rxv[2] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1, 0, 8'h5A};
        rxv[3] = '{8'h81, 1'b1, 1'b0, 1'b0, 0, 1, 8'h5A};
        rxv[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 0, 1, 8'h5A};
        rxv[5] = '{8'h01, 1'b0, 1'b0, 1'b1, 1, 0, 8'h01};
        rxv[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1, 0, 8'hFF};

        reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
        bfm_c_low = 1'b0; bfm_d_low = 1'b0;
        clocks(5);
        check("reset_busy", int'(tx_busy), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_pulses", int'(tx_done) + int'(tx_error) + int'(rx_valid) + int'(rx_error), 0);
        check("reset_ps2c_released", int'(ps2c === 1'b1), 1);
        check("reset_ps2d_released", int'(ps2d === 1'b1), 1);
        reset = 1'b0;
        clocks(20);

        for (int v = 0; v < 5; v++) begin
            snap();
            run_tx(txv[v].data, txv[v].ack, 10, bits, inh, rts);
            t = 0;
            while (tx_busy && t < 4 * TMO) begin
                t++;
                clocks(1);
            end
            clocks(5);
            check($sformatf("tx%0d_idle_in_time", v), int'(t < 4 * TMO), 1);
            check($sformatf("tx%0d_inhibit_len", v), inh, INH);
            check($sformatf("tx%0d_rts_len", v), rts, RTS);
            check($sformatf("tx%0d_bits", v), int'(bits), int'(txv[v].exp_bits));
            check($sformatf("tx%0d_done", v), n_done - s_done, txv[v].exp_done);
            check($sformatf("tx%0d_error", v), n_txerr - s_txerr, txv[v].exp_err);
            check($sformatf("tx%0d_no_rx_pulse", v), (n_valid - s_valid) + (n_rxerr - s_rxerr), 0);
            check($sformatf("tx%0d_ps2c_released", v), int'(ps2c === 1'b1), 1);
            check($sformatf("tx%0d_ps2d_released", v), int'(ps2d === 1'b1), 1);
            clocks(50);
        end

        for (int v = 0; v < 7; v++) begin
            snap();
            send_frame({rxv[v].stop, rxv[v].par, rxv[v].data, rxv[v].start}, 11);
            clocks(50);
            check($sformatf("rx%0d_valid", v), n_valid - s_valid, rxv[v].exp_valid);
            check($sformatf("rx%0d_error", v), n_rxerr - s_rxerr, rxv[v].exp_err);
            check($sformatf("rx%0d_data", v), int'(rx_data), int'(rxv[v].exp_rx));
            check($sformatf("rx%0d_busy", v), int'(tx_busy), 0);
            check($sformatf("rx%0d_no_tx_pulse", v), (n_done - s_done) + (n_txerr - s_txerr), 0);
        end

        // Device stops after 4 bits: error only once the timeout has elapsed.
        snap();
        send_frame(11'b111_0101_0100, 4);
        clocks(TMO - 300);
        check("rxto_not_early", n_rxerr - s_rxerr, 0);
        check("rxto_busy_in_rx", int'(tx_busy), 1);
        clocks(600);
        check("rxto_error", n_rxerr - s_rxerr, 1);
        check("rxto_no_valid", n_valid - s_valid, 0);
        check("rxto_idle", int'(tx_busy), 0);
        check("rxto_data_kept", int'(rx_data), 8'hFF);
        snap();
        send_frame({1'b1, 1'b1, 8'hAA, 1'b0}, 11);
        clocks(50);
        check("rx_after_to_valid", n_valid - s_valid, 1);
        check("rx_after_to_data", int'(rx_data), 8'hAA);

        // Reset in the middle of shifting a byte.
        snap();
        run_tx(8'h00, 1'b0, 3, bits, inh, rts);
        clocks(10);
        check("rst_pre_busy", int'(tx_busy), 1);
        check("rst_pre_ps2d_low", int'(ps2d === 1'b0), 1);
        reset = 1'b1;
        clocks(1);
        check("rst_ps2c_released", int'(ps2c === 1'b1), 1);
        check("rst_ps2d_released", int'(ps2d === 1'b1), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_rx_data", int'(rx_data), 0);
        reset = 1'b0;
        clocks(200);
        check("rst_no_pulses", (n_done - s_done) + (n_txerr - s_txerr) +
              (n_valid - s_valid) + (n_rxerr - s_rxerr), 0);
        check("rst_stays_idle", int'(tx_busy), 0);

        check("pulses_never_overlap", n_overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
